muldiv_arbiter: RTL and testbench
=================================

# muldiv_arbiter

Shares the single iterative 32-cycle multiply/divide unit between two issue-side requesters (RV32M ops) and sequences it. Grants one request at a time round-robin, converts signed operands to magnitudes, pulses the unit, and sign-corrects and selects the 32-bit result. Returns the result to the granted requester over a valid/ready handshake. Resolves divide-by-zero and signed overflow without starting the unit.

## Interface
- No parameters. Data width is fixed at 32 and the requester count at 2.
- clk  in  1  clock.
- rst_n  in  1  Reset, synchronous, active-low. It is the same net as the unit's reset.
- flush  in  1  Discards the in-flight op. Level, sampled each cycle.
- req_valid  in  2  Request valid. Bit i is requester i.
- req_ready  out  2  Request accepted. One-hot or zero; a request transfers in the cycle where valid and ready are both high.
- req_op  in  6  {op1, op0}, each 3 bits. Encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- req_a, req_b  in  64  {req1, req0} operands, 32 bits each.
- rsp_valid  out  2  Response valid, one-hot. Held until accepted.
- rsp_ready  in  2  Response accept.
- rsp_data  out  32  Result for the requester flagged in rsp_valid.
- md_valid  out  1  Start pulse to the unit. Single cycle.
- md_mode  out  1  0 = multiply, 1 = divide. Equals op[2].
- md_in_A, md_in_B  out  32  Operand magnitudes.
- md_ready  in  1  Unit done. High for exactly one cycle.
- md_out  in  64  Unit result, valid while md_ready is high.
  - Multiply: full unsigned product.
  - Divide: [31:0] is the quotient, [63:32] is the remainder.

## Operation
- States: IDLE, ISSUE, BUSY, DONE, DRAIN.
- **IDLE**
  - Arbitration: if both req_valid bits are high, grant the requester that was not served last (pointer `last`, reset value 1, so requester 0 wins first). A single valid requester is granted directly.
  - The grant asserts req_ready[i] combinationally in the same cycle.
  - On grant, capture op, id, sign flags, magnitudes, and the raw A.
  - Sign of A (sA) applies for MULH, MULHSU, DIV, REM. Sign of B (sB) applies for MULH, DIV, REM.
  - Magnitude: |x| = sign ? ~x+1 : x.
  - Special cases go straight to DONE with the result preloaded:
    - DIV/DIVU with b == 0: result 0xFFFFFFFF.
    - REM/REMU with b == 0: result a.
    - DIV with a == 0x80000000 and b == 0xFFFFFFFF: result 0x80000000.
    - REM with the same operands: result 0.
  - Otherwise go to ISSUE.
- **ISSUE**: md_valid = 1 with the captured magnitudes and mode; go to BUSY.
- **BUSY**: wait for md_ready, then load the result and go to DONE.
  - Multiply: P = md_out, negated as a 64-bit two's complement when neg = 1.
    - neg = sA^sB for MULH; neg = sA for MULHSU; neg = 0 for MUL/MULHU.
    - MUL returns P[31:0]. The others return P[63:32].
  - DIV returns the quotient, negated when sA^sB. DIVU returns it as-is.
  - REM returns the remainder, negated when sA. REMU returns it as-is.
- **DONE**: rsp_valid[id] = 1 and rsp_data is stable. When rsp_ready[id] is high, go to IDLE and set last = id. req_ready stays 0.
- **flush**
  - In ISSUE: md_valid is still issued and the state goes to DRAIN.
  - In BUSY: go to DRAIN. If md_ready is also high that cycle, go to IDLE instead.
  - In DONE: drop the response and go to IDLE.
  - In IDLE: no grant that cycle.
- **DRAIN**: wait for md_ready, discard the result, go to IDLE. flush is ignored in this state.
- `last` is updated only on a completed response handshake.

## Timing
- Reset values: state IDLE, last 1; req_ready, rsp_valid, md_valid, md_mode = 0; rsp_data, md_in_A, md_in_B = 0.
- Normal op:
  - Accept at cycle 0, ISSUE at cycle 1 (md_valid high).
  - md_ready arrives at cycle 34 (the unit takes 33 cycles from its start pulse).
  - rsp_valid is high from cycle 35.
- Special case: rsp_valid is high at cycle 1.
- Back-to-back: after the response handshake at cycle n, the next grant can occur at cycle n+1.
- Every output is registered except req_ready.
- md_valid is never high outside ISSUE. At most one op is in the unit at a time.
- Reset mid-operation returns the block to IDLE on the next edge. No response is produced.

## Test plan
- req0 MUL a=7, b=0xFFFFFFFD: req_ready[0] at cycle 0, md_valid at cycle 1, rsp_valid[0] at cycle 35 with rsp_data 0xFFFFFFEB.
- req1 MULH a=b=0x80000000 gives 0x40000000. MULHSU a=0xFFFFFFFF, b=2 gives 0xFFFFFFFF. MULHU a=b=0xFFFFFFFF gives 0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 gives 0xFFFFFFFD. REM with the same operands gives 0xFFFFFFFF. DIVU a=100, b=7 gives 14.
- DIV a=5, b=0: rsp at cycle 1 with 0xFFFFFFFF and md_valid never asserted. REM a=0x80000000, b=0xFFFFFFFF: rsp at cycle 1 with 0.
- Both requesters valid after reset: req0 is served first. Hold rsp_ready low for 3 cycles and check that rsp_data stays stable. req1 is then granted the cycle after the handshake. Repeat with both valid again and check that req0 is served.
- flush asserted at cycle 10 of a DIV: state goes to DRAIN and no rsp_valid follows. After md_ready the block returns to IDLE and a pending request is granted the next cycle. Also apply rst_n low mid-BUSY and check that all outputs return to their reset values.

Source files
------------

// File: rtl/muldiv_arbiter_if.sv
// ----------------------------------------------------------------------------
// muldiv_arbiter_if
// Bundles the requester-side and multiply/divide-unit-side signals of the
// muldiv_arbiter.
//   requester side : req_valid/req_ready/req_op/req_a/req_b (2 requesters)
//                    rsp_valid/rsp_ready/rsp_data
//   unit side      : md_valid/md_mode/md_in_A/md_in_B (to unit)
//                    md_ready/md_out (from unit)
// Modports:
//   master : the environment (requesters plus the iterative unit)
//   slave  : the arbiter itself
// ----------------------------------------------------------------------------
interface muldiv_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [5:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic        md_valid;
    logic        md_mode;
    logic [31:0] md_in_A;
    logic [31:0] md_in_B;
    logic        md_ready;
    logic [63:0] md_out;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready, md_ready, md_out,
        input  req_ready, rsp_valid, rsp_data, md_valid, md_mode, md_in_A, md_in_B
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready, md_ready, md_out,
        output req_ready, rsp_valid, rsp_data, md_valid, md_mode, md_in_A, md_in_B
    );
endinterface

// File: rtl/muldiv_arbiter.sv
// ----------------------------------------------------------------------------
// muldiv_arbiter
// Shares one iterative 32-cycle multiply/divide unit between two requesters.
// Round-robin grant, operand magnitude conversion, start pulse to the unit,
// sign correction of the result and a valid/ready response. Divide-by-zero
// and signed overflow are answered directly without starting the unit.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset (shared with the unit)
//   flush : discard the in-flight op (level)
//   bus   : muldiv_arbiter_if.slave, requester and unit signals
// Every output is registered except bus.req_ready.
// ----------------------------------------------------------------------------
module muldiv_arbiter (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    muldiv_arbiter_if.slave       bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_BUSY  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    // Two's-complement magnitude when the sign flag is set.
    function automatic logic [31:0] mag32(input logic sgn, input logic [31:0] x);
        return sgn ? (~x + 32'd1) : x;
    endfunction

    state_t      state_q;
    logic        last_q;
    logic        id_q;
    logic [2:0]  op_q;
    logic        sa_q;
    logic        sb_q;
    logic [1:0]  rsp_valid_q;
    logic [31:0] rsp_data_q;
    logic        md_valid_q;
    logic        md_mode_q;
    logic [31:0] md_in_a_q;
    logic [31:0] md_in_b_q;

    logic        grant_en_s;
    logic        grant_id_s;
    logic [1:0]  req_ready_s;
    logic [2:0]  sel_op_s;
    logic [31:0] sel_a_s;
    logic [31:0] sel_b_s;
    logic        sa_s;
    logic        sb_s;
    logic        special_s;
    logic [31:0] special_res_d;
    logic [63:0] prod_s;
    logic [31:0] busy_res_d;

    // Round-robin grant and selection of the granted requester's operands.
    always_comb begin
        grant_en_s = (state_q == S_IDLE) && !flush && (bus.req_valid != 2'b00);
        if (bus.req_valid == 2'b11) begin
            grant_id_s = ~last_q;
        end else begin
            grant_id_s = bus.req_valid[1];
        end
        if (grant_en_s) begin
            req_ready_s = {grant_id_s, ~grant_id_s};
        end else begin
            req_ready_s = 2'b00;
        end
        sel_op_s = grant_id_s ? bus.req_op[5:3] : bus.req_op[2:0];
        sel_a_s  = grant_id_s ? bus.req_a[63:32] : bus.req_a[31:0];
        sel_b_s  = grant_id_s ? bus.req_b[63:32] : bus.req_b[31:0];
    end

    // Sign flags: A is signed for MULH/MULHSU/DIV/REM, B for MULH/DIV/REM.
    always_comb begin
        sa_s = 1'b0;
        sb_s = 1'b0;
        case (sel_op_s)
            OP_MULH, OP_DIV, OP_REM: begin
                sa_s = sel_a_s[31];
                sb_s = sel_b_s[31];
            end
            OP_MULHSU: begin
                sa_s = sel_a_s[31];
            end
            default: begin
                sa_s = 1'b0;
                sb_s = 1'b0;
            end
        endcase
    end

    // Divide-by-zero and signed-overflow results resolved at grant time.
    always_comb begin
        special_s     = 1'b0;
        special_res_d = 32'd0;
        if (sel_op_s[2] && (sel_b_s == 32'd0)) begin
            special_s     = 1'b1;
            special_res_d = sel_op_s[1] ? sel_a_s : 32'hFFFF_FFFF;
        end else if (((sel_op_s == OP_DIV) || (sel_op_s == OP_REM)) &&
                     (sel_a_s == 32'h8000_0000) && (sel_b_s == 32'hFFFF_FFFF)) begin
            special_s     = 1'b1;
            special_res_d = sel_op_s[1] ? 32'd0 : 32'h8000_0000;
        end else begin
            special_s     = 1'b0;
            special_res_d = 32'd0;
        end
    end

    // Sign correction of the unit result. sb_q is zero for MULHSU and both
    // flags are zero for the unsigned ops, so sa^sb covers every multiply
    // and quotient case.
    always_comb begin
        prod_s     = (sa_q ^ sb_q) ? (~bus.md_out + 64'd1) : bus.md_out;
        busy_res_d = 32'd0;
        if (op_q[2]) begin
            if (op_q[1]) begin
                busy_res_d = mag32(sa_q, bus.md_out[63:32]);
            end else begin
                busy_res_d = mag32(sa_q ^ sb_q, bus.md_out[31:0]);
            end
        end else if (op_q == OP_MUL) begin
            busy_res_d = prod_s[31:0];
        end else begin
            busy_res_d = prod_s[63:32];
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            op_q        <= 3'd0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= 32'd0;
            md_valid_q  <= 1'b0;
            md_mode_q   <= 1'b0;
            md_in_a_q   <= 32'd0;
            md_in_b_q   <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_en_s) begin
                        id_q      <= grant_id_s;
                        op_q      <= sel_op_s;
                        sa_q      <= sa_s;
                        sb_q      <= sb_s;
                        md_mode_q <= sel_op_s[2];
                        md_in_a_q <= mag32(sa_s, sel_a_s);
                        md_in_b_q <= mag32(sb_s, sel_b_s);
                        if (special_s) begin
                            rsp_data_q  <= special_res_d;
                            rsp_valid_q <= {grant_id_s, ~grant_id_s};
                            state_q     <= S_DONE;
                        end else begin
                            md_valid_q <= 1'b1;
                            state_q    <= S_ISSUE;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    // The start pulse has gone out; a flush must still drain it.
                    md_valid_q <= 1'b0;
                    state_q    <= flush ? S_DRAIN : S_BUSY;
                end
                S_BUSY: begin
                    if (flush) begin
                        state_q <= bus.md_ready ? S_IDLE : S_DRAIN;
                    end else if (bus.md_ready) begin
                        rsp_data_q  <= busy_res_d;
                        rsp_valid_q <= {id_q, ~id_q};
                        state_q     <= S_DONE;
                    end else begin
                        state_q <= S_BUSY;
                    end
                end
                S_DONE: begin
                    if (flush) begin
                        rsp_valid_q <= 2'b00;
                        state_q     <= S_IDLE;
                    end else if (bus.rsp_ready[id_q]) begin
                        rsp_valid_q <= 2'b00;
                        last_q      <= id_q;
                        state_q     <= S_IDLE;
                    end else begin
                        state_q <= S_DONE;
                    end
                end
                S_DRAIN: begin
                    state_q <= bus.md_ready ? S_IDLE : S_DRAIN;
                end
                default: begin
                    rsp_valid_q <= 2'b00;
                    md_valid_q  <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.md_valid  = md_valid_q;
    assign bus.md_mode   = md_mode_q;
    assign bus.md_in_A   = md_in_a_q;
    assign bus.md_in_B   = md_in_b_q;
endmodule

// File: tb/tb_muldiv_arbiter.sv
// ----------------------------------------------------------------------------
// tb_muldiv_arbiter
// Directed bench for muldiv_arbiter. The bench also plays the iterative unit:
// it answers a start pulse 33 cycles later with the unsigned product or
// {remainder, quotient} of the magnitudes it was handed.
// ----------------------------------------------------------------------------
module tb_muldiv_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    muldiv_arbiter_if bus();

    muldiv_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] onehot(input int id);
        return (id == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [63:0] unit_model(input logic mode, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] r;
        if (mode) r = {a % b, a / b};
        else      r = {32'd0, a} * {32'd0, b};
        return r;
    endfunction

    task automatic set_req(input int id, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        if (id == 1) begin
            bus.req_op[5:3]   = op;
            bus.req_a[63:32]  = a;
            bus.req_b[63:32]  = b;
        end else begin
            bus.req_op[2:0]   = op;
            bus.req_a[31:0]   = a;
            bus.req_b[31:0]   = b;
        end
    endtask

    // Entered at posedge+1 in IDLE; returns at posedge+1 in IDLE.
    task automatic run_op(input string tag, input int id, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_ma, input logic [31:0] exp_mb,
                          input logic [31:0] exp_res, input bit special);
        logic        m_mode;
        logic [31:0] m_a;
        logic [31:0] m_b;
        set_req(id, op, a, b);
        bus.req_valid = onehot(id);
        @(negedge clk);
        check({tag, "_req_ready"}, bus.req_ready, onehot(id));
        tick();
        bus.req_valid = 2'b00;
        @(negedge clk);
        if (special) begin
            check({tag, "_md_valid"}, bus.md_valid, 1'b0);
            check({tag, "_rsp_valid"}, bus.rsp_valid, onehot(id));
            check({tag, "_rsp_data"}, bus.rsp_data, exp_res);
        end else begin
            check({tag, "_md_valid"}, bus.md_valid, 1'b1);
            check({tag, "_md_in_A"}, bus.md_in_A, exp_ma);
            check({tag, "_md_in_B"}, bus.md_in_B, exp_mb);
            check({tag, "_md_mode"}, bus.md_mode, op[2]);
            m_mode = bus.md_mode;
            m_a    = bus.md_in_A;
            m_b    = bus.md_in_B;
            repeat (33) tick();
            bus.md_out   = unit_model(m_mode, m_a, m_b);
            bus.md_ready = 1'b1;
            @(negedge clk);
            check({tag, "_rsp_early"}, bus.rsp_valid, 2'b00);
            tick();
            bus.md_ready = 1'b0;
            bus.md_out   = 64'd0;
            @(negedge clk);
            check({tag, "_rsp_valid"}, bus.rsp_valid, onehot(id));
            check({tag, "_rsp_data"}, bus.rsp_data, exp_res);
        end
        tick();
        bus.rsp_ready = onehot(id);
        tick();
        bus.rsp_ready = 2'b00;
    endtask

    initial begin
        int bad;
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.req_valid = 2'b00;
        bus.req_op    = 6'd0;
        bus.req_a     = 64'd0;
        bus.req_b     = 64'd0;
        bus.rsp_ready = 2'b00;
        bus.md_ready  = 1'b0;
        bus.md_out    = 64'd0;
        tick();
        tick();
        @(negedge clk);
        check("rst_req_ready", bus.req_ready, 2'b00);
        check("rst_rsp_valid", bus.rsp_valid, 2'b00);
        check("rst_md_valid", bus.md_valid, 1'b0);
        check("rst_md_mode", bus.md_mode, 1'b0);
        check("rst_rsp_data", bus.rsp_data, 32'd0);
        check("rst_md_in", {bus.md_in_A, bus.md_in_B}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Both valid after reset: req0 first, held response, then req1.
        set_req(0, DIV, 32'd5, 32'd0);
        set_req(1, REM, 32'h1234_5678, 32'd0);
        bus.req_valid = 2'b11;
        @(negedge clk);
        check("arb_first", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b10;
        @(negedge clk);
        check("arb_rsp0_valid", bus.rsp_valid, 2'b01);
        check("arb_rsp0_data", bus.rsp_data, 32'hFFFF_FFFF);
        check("arb_done_no_grant", bus.req_ready, 2'b00);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("arb_hold", {bus.rsp_valid, bus.rsp_data}, {2'b01, 32'hFFFF_FFFF});
        end
        tick();
        bus.rsp_ready = 2'b01;
        tick();
        bus.rsp_ready = 2'b00;
        @(negedge clk);
        check("arb_second", bus.req_ready, 2'b10);
        tick();
        bus.req_valid = 2'b00;
        @(negedge clk);
        check("arb_rsp1", {bus.rsp_valid, bus.rsp_data}, {2'b10, 32'h1234_5678});
        tick();
        bus.rsp_ready = 2'b10;
        tick();
        bus.rsp_ready = 2'b00;
        bus.req_valid = 2'b11;
        @(negedge clk);
        check("arb_rr_back", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b01;
        @(negedge clk);
        check("arb_rr_rsp", bus.rsp_valid, 2'b01);
        tick();
        bus.rsp_ready = 2'b00;

        // Arithmetic through the unit and the special cases.
        run_op("mul",    0, MUL,    32'd7,          32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        run_op("mulh",   1, MULH,   32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        run_op("mulhsu", 0, MULHSU, 32'hFFFF_FFFF, 32'd2,          32'd1,          32'd2,          32'hFFFF_FFFF, 1'b0);
        run_op("mulhu",  1, MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_op("div",    0, DIV,    32'hFFFF_FFF9, 32'd2,          32'd7,          32'd2,          32'hFFFF_FFFD, 1'b0);
        run_op("rem",    1, REM,    32'hFFFF_FFF9, 32'd2,          32'd7,          32'd2,          32'hFFFF_FFFF, 1'b0);
        run_op("divu",   0, DIVU,   32'd100,        32'd7,          32'd100,        32'd7,          32'd14,        1'b0);
        run_op("div0",   1, DIV,    32'd5,          32'd0,          32'd0,          32'd0,          32'hFFFF_FFFF, 1'b1);
        run_op("remu0",  0, REMU,   32'hCAFE_0001, 32'd0,          32'd0,          32'd0,          32'hCAFE_0001, 1'b1);
        run_op("removf", 0, REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,          32'd0,          32'd0,         1'b1);
        run_op("divovf", 1, DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,          32'd0,          32'h8000_0000, 1'b1);

        // flush in IDLE blocks the grant.
        set_req(0, DIVU, 32'd9, 32'd3);
        bus.req_valid = 2'b01;
        flush = 1'b1;
        @(negedge clk);
        check("flush_idle_no_grant", bus.req_ready, 2'b00);
        tick();
        flush = 1'b0;

        // flush mid-DIV: drain, no response, then pending req1 is granted.
        set_req(0, DIV, 32'd100, 32'd7);
        @(negedge clk);
        check("fl_req_ready", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b00;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_req(1, DIVU, 32'd3, 32'd0);
        bus.req_valid = 2'b10;
        bad = 0;
        for (int c = 11; c < 34; c++) begin
            @(negedge clk);
            if (bus.req_ready != 2'b00 || bus.rsp_valid != 2'b00 || bus.md_valid != 1'b0) bad++;
            tick();
        end
        check("fl_drain_quiet", bad, 0);
        bus.md_out   = 64'd0;
        bus.md_ready = 1'b1;
        @(negedge clk);
        check("fl_drain_hold", {bus.req_ready, bus.rsp_valid}, 4'b0000);
        tick();
        bus.md_ready = 1'b0;
        @(negedge clk);
        check("fl_next_grant", {bus.req_ready, bus.rsp_valid}, 4'b1000);
        tick();
        bus.req_valid = 2'b00;
        @(negedge clk);
        check("fl_next_rsp", {bus.rsp_valid, bus.rsp_data}, {2'b10, 32'hFFFF_FFFF});
        tick();
        bus.rsp_ready = 2'b10;
        tick();
        bus.rsp_ready = 2'b00;

        // Reset in the middle of BUSY.
        set_req(0, DIV, 32'd100, 32'd7);
        bus.req_valid = 2'b01;
        tick();
        bus.req_valid = 2'b00;
        repeat (5) tick();
        @(negedge clk);
        check("rb_pre_mode", bus.md_mode, 1'b1);
        tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        check("rb_rsp_valid", bus.rsp_valid, 2'b00);
        check("rb_md", {bus.md_valid, bus.md_mode}, 2'b00);
        check("rb_rsp_data", bus.rsp_data, 32'd0);
        check("rb_md_in", {bus.md_in_A, bus.md_in_B}, 64'd0);
        check("rb_req_ready", bus.req_ready, 2'b00);
        tick();
        rst_n = 1'b1;
        tick();
        run_op("post_rst", 0, DIVU, 32'd7, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
